// File: rtl/silver_arbiter.sv
// rtl/silver_arbiter.sv - four-port flit marker with LFSR start port and starvation override
module silver_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] northad,
   input  logic [10:0] southad,
   input  logic [10:0] eastad,
   input  logic [10:0] westad,
   input  logic        adv,
   output logic [10:0] nad,
   output logic [10:0] sad,
   output logic [10:0] ead,
   output logic [10:0] wad,
   output logic        silver_valid,
   output logic [1:0]  silver_port
);

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [2:0] CNT_MAX   = 3'd7;

   // Port order everywhere: 0=N, 1=S, 2=E, 3=W
   logic [3:0][10:0] w_in;
   logic [3:0]       w_valid;
   logic [1:0]       w_start;
   logic [7:0]       w_lfsr_next;

   logic             w_forced_hit;
   logic [1:0]       w_forced_idx;
   logic             w_scan_hit;
   logic [1:0]       w_scan_idx;
   logic [1:0]       w_scan_cand;
   logic             w_choice_hit;
   logic [1:0]       w_choice_idx;
   logic [3:0]       w_mark;

   logic [7:0]       r_lfsr;
   logic [3:0][2:0]  r_cnt;
   logic [3:0][10:0] r_out;
   logic             r_silver_valid;
   logic [1:0]       r_silver_port;

   assign w_in[0] = northad;
   assign w_in[1] = southad;
   assign w_in[2] = eastad;
   assign w_in[3] = westad;

   assign w_start     = r_lfsr[1:0];
   assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

   // A port is valid only when bit 10 is a clean 1 and the destination field has no unknowns
   always_comb begin
      w_valid = '0;
      for (int p = 0; p < 4; p++) begin
         w_valid[p] = (w_in[p][10] === 1'b1) && ((^w_in[p][5:0]) !== 1'bx);
      end
   end

   // Starvation override: lowest-index valid port whose counter is saturated
   always_comb begin
      w_forced_hit = 1'b0;
      w_forced_idx = 2'd0;
      for (int p = 3; p >= 0; p--) begin
         if (w_valid[p] && (r_cnt[p] == CNT_MAX)) begin
            w_forced_hit = 1'b1;
            w_forced_idx = 2'(p);
         end
      end
   end

   // Rotating scan from the LFSR start port; walking offsets downward leaves the nearest hit
   always_comb begin
      w_scan_hit  = 1'b0;
      w_scan_idx  = 2'd0;
      w_scan_cand = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_scan_cand = w_start + 2'(k);
         if (w_valid[w_scan_cand]) begin
            w_scan_hit = 1'b1;
            w_scan_idx = w_scan_cand;
         end
      end
   end

   // Final choice and the one-hot mark vector derived from it
   always_comb begin
      w_choice_hit = w_forced_hit | w_scan_hit;
      w_choice_idx = w_forced_hit ? w_forced_idx : w_scan_idx;
      w_mark       = '0;
      if (w_choice_hit) begin
         w_mark[w_choice_idx] = 1'b1;
      end
   end

   // LFSR advances once per accepted stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else if (adv) begin
         r_lfsr <= w_lfsr_next;
      end
   end

   // Starvation counters: count up while waiting, clear when served or idle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (adv) begin
         for (int p = 0; p < 4; p++) begin
            if (w_valid[p] && !w_mark[p]) begin
               r_cnt[p] <= (r_cnt[p] == CNT_MAX) ? CNT_MAX : r_cnt[p] + 3'd1;
            end else begin
               r_cnt[p] <= 3'd0;
            end
         end
      end
   end

   // Output flits: pass everything through, rewrite bit 9 as the silver mark
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
      end else if (adv) begin
         for (int p = 0; p < 4; p++) begin
            r_out[p] <= {w_in[p][10], w_mark[p], w_in[p][8:0]};
         end
      end
   end

   // Silver status registered alongside the flits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_silver_valid <= 1'b0;
         r_silver_port  <= 2'd0;
      end else if (adv) begin
         r_silver_valid <= w_choice_hit;
         r_silver_port  <= w_choice_hit ? w_choice_idx : 2'd0;
      end
   end

   assign nad          = r_out[0];
   assign sad          = r_out[1];
   assign ead          = r_out[2];
   assign wad          = r_out[3];
   assign silver_valid = r_silver_valid;
   assign silver_port  = r_silver_port;

endmodule
